// File: rtl/systolic_mm_stream_pkg.sv
// Shared types and helpers for the streaming systolic matrix multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  // Quantiser works on a fixed 64-bit view of the accumulator.
  localparam int QW = 64;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  // Accumulator width that cannot overflow for K products of two N-bit operands.
  function automatic int acc_width(input int n, input int k);
    return 2 * n + clog2(k);
  endfunction

  // Clamp a sign/zero-extended accumulator into an m-bit result range.
  function automatic logic [QW-1:0] saturate(input logic [QW-1:0] acc, input int m,
                                             input bit sgn);
    logic signed [QW-1:0] s_acc, s_max, s_min;
    logic [QW-1:0] u_max, r;
    r = acc;
    s_acc = acc;
    if (sgn) begin
      s_max = (64'sd1 <<< (m - 1)) - 64'sd1;
      s_min = -(64'sd1 <<< (m - 1));
      if (s_acc > s_max) r = s_max;
      else if (s_acc < s_min) r = s_min;
    end else begin
      u_max = (64'd1 << m) - 64'd1;
      if (acc > u_max) r = u_max;
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_mm_stream_pe.sv
// Output-stationary PE: forwards A right and B down, accumulates A*B locally.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int N      = 8,
  parameter int ACC    = 20,
  parameter int SIGNED = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic [N-1:0]   a_out,
  output logic [N-1:0]   b_out,
  output logic [ACC-1:0] acc
);

  logic [ACC-1:0] prod;

  if (SIGNED != 0) begin : g_smul
    logic signed [2*N-1:0] p;
    assign p    = $signed(a_in) * $signed(b_in);
    assign prod = ACC'(p);
  end else begin : g_umul
    logic [2*N-1:0] p;
    assign p    = a_in * b_in;
    assign prod = ACC'(p);
  end

  // Operand pass-through registers and the MAC; clr restarts a job's sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr) acc <= '0;
      else     acc <= acc + prod;
    end
  end

endmodule

// File: rtl/systolic_mm_stream.sv
// Streaming R x C systolic matrix multiplier with job FSM and handshaked I/O.
module systolic_mm_stream
  import systolic_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int R      = 4,
  parameter int C      = 4,
  parameter int K      = 16,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [R*N-1:0]   a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [C*N-1:0]   b_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [R*C*M-1:0] res_data,
  output logic             done
);

  localparam int ACC = acc_width(N, K);
  localparam int BCW = (clog2(K) > 0) ? clog2(K) : 1;
  localparam int DCW = (clog2(R + C) > 0) ? clog2(R + C) : 1;

  state_t         state;
  logic [BCW-1:0] bcnt;
  logic [DCW-1:0] dcnt;
  logic           fire, clr;

  logic [R-1:0][N-1:0] a_inj, a_sk;
  logic [C-1:0][N-1:0] b_inj, b_sk;
  logic [N-1:0]        a_h [R][C+1];
  logic [N-1:0]        b_v [R+1][C];
  logic [ACC-1:0]      acc [R][C];
  logic [R*C*M-1:0]    q_flat, res_q;
  logic [R-1:0]        unused_a;
  logic [C-1:0]        unused_b;

  // A and B are only ever taken together; each side's ready mirrors the other's valid.
  assign fire     = (state == LOAD) && a_valid && b_valid;
  assign clr      = (state == IDLE) && start;
  assign a_ready  = (state == LOAD) && b_valid;
  assign b_ready  = (state == LOAD) && a_valid;
  assign res_data = res_q;

  // Non-beat cycles feed zeros so bubbles contribute nothing to the sums.
  for (genvar i = 0; i < R; i++) begin : g_ainj
    assign a_inj[i] = fire ? a_data[i*N +: N] : '0;
  end
  for (genvar j = 0; j < C; j++) begin : g_binj
    assign b_inj[j] = fire ? b_data[j*N +: N] : '0;
  end

  // Row i of A is delayed i cycles so it meets column j of B on the diagonal.
  for (genvar i = 0; i < R; i++) begin : g_askew
    if (i == 0) begin : g_d0
      assign a_sk[i] = a_inj[i];
    end else begin : g_dn
      logic [N-1:0] sr [i];
      // Skew shift register for this A row.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < i; k++) sr[k] <= '0;
        end else begin
          sr[0] <= a_inj[i];
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      end
      assign a_sk[i] = sr[i-1];
    end
  end

  for (genvar j = 0; j < C; j++) begin : g_bskew
    if (j == 0) begin : g_d0
      assign b_sk[j] = b_inj[j];
    end else begin : g_dn
      logic [N-1:0] sr [j];
      // Skew shift register for this B column.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else begin
          sr[0] <= b_inj[j];
          for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
        end
      end
      assign b_sk[j] = sr[j-1];
    end
  end

  // PE grid plus per-PE quantiser.
  for (genvar i = 0; i < R; i++) begin : g_row
    assign a_h[i][0]   = a_sk[i];
    assign unused_a[i] = ^a_h[i][C];
    for (genvar j = 0; j < C; j++) begin : g_col
      logic [QW-1:0] acc64;
      systolic_pe #(.N(N), .ACC(ACC), .SIGNED(SIGNED)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc[i][j])
      );
      if (SIGNED != 0) begin : g_sext
        assign acc64 = QW'($signed(acc[i][j]));
      end else begin : g_zext
        assign acc64 = QW'(acc[i][j]);
      end
      assign q_flat[(i*C+j)*M +: M] = (SAT != 0) ? M'(saturate(acc64, M, SIGNED != 0))
                                                 : M'(acc64);
    end
  end

  for (genvar j = 0; j < C; j++) begin : g_btop
    assign b_v[0][j]   = b_sk[j];
    assign unused_b[j] = ^b_v[R][j];
  end

  // Job FSM: load K beats, drain the wavefront, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      done      <= 1'b0;
      res_q     <= '0;
      bcnt      <= '0;
      dcnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
            bcnt  <= '0;
          end
        end
        LOAD: begin
          if (fire) begin
            if (bcnt == BCW'(K - 1)) begin
              state <= DRAIN;
              dcnt  <= '0;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Last PE sees the final beat R+C-2 edges later; one extra edge of margin
          // puts res_valid R+C edges after the final beat.
          if (dcnt == DCW'(R + C - 1)) begin
            state     <= OUT;
            res_valid <= 1'b1;
            res_q     <= q_flat;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Scoreboard bench: jobs push expected words, monitors pop on result handshake.
module tb_systolic_mm_stream;

  localparam int N = 8, M = 8, R = 4, C = 4, K = 16;
  localparam int W = R * C * M;

  logic clk = 1'b0;
  logic rst, start, a_valid, b_valid, res_ready;
  logic [R*N-1:0] a_data;
  logic [C*N-1:0] b_data;

  logic busy_s, a_ready_s, b_ready_s, res_valid_s, done_s;
  logic busy_w, a_ready_w, b_ready_w, res_valid_w, done_w;
  logic [W-1:0] res_data_s, res_data_w;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] q_s[$];
  logic [W-1:0] q_w[$];
  logic [W-1:0] exp_s, exp_w;
  logic [N-1:0] a_beats [K][R];
  logic [N-1:0] b_beats [K][C];

  always #5 clk = ~clk;

  systolic_mm_stream #(.N(N), .M(M), .R(R), .C(C), .K(K), .SIGNED(1), .SAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy_s),
    .a_valid(a_valid), .a_ready(a_ready_s), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready_s), .b_data(b_data),
    .res_valid(res_valid_s), .res_ready(res_ready), .res_data(res_data_s), .done(done_s)
  );

  systolic_mm_stream #(.N(N), .M(M), .R(R), .C(C), .K(K), .SIGNED(1), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .start(start), .busy(busy_w),
    .a_valid(a_valid), .a_ready(a_ready_w), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready_w), .b_data(b_data),
    .res_valid(res_valid_w), .res_ready(res_ready), .res_data(res_data_w), .done(done_w)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Saturating instance monitor.
  always @(negedge clk) begin
    if (!rst && res_valid_s && res_ready) begin
      if (q_s.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL res_sat_unexpected: got %h expected none", res_data_s);
      end else begin
        exp_s = q_s.pop_front();
        check("res_sat", res_data_s, exp_s);
      end
    end
  end

  // Wrapping instance monitor.
  always @(negedge clk) begin
    if (!rst && res_valid_w && res_ready) begin
      if (q_w.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL res_wrap_unexpected: got %h expected none", res_data_w);
      end else begin
        exp_w = q_w.pop_front();
        check("res_wrap", res_data_w, exp_w);
      end
    end
  end

  function automatic logic [W-1:0] fill(input logic [M-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int p = 0; p < R * C; p++) r[p*M +: M] = v;
    return r;
  endfunction

  task automatic set_uniform(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int k = 0; k < K; k++) begin
      for (int i = 0; i < R; i++) a_beats[k][i] = a;
      for (int j = 0; j < C; j++) b_beats[k][j] = b;
    end
  endtask

  task automatic set_lanes();
    for (int k = 0; k < K; k++) begin
      for (int i = 0; i < R; i++) a_beats[k][i] = N'(i + 1);
      for (int j = 0; j < C; j++) b_beats[k][j] = N'(j + 1);
    end
  endtask

  task automatic do_beat(input int k, input bit stall);
    bit fired;
    int tries;
    fired = 1'b0;
    tries = 0;
    a_valid = 1'b1;
    for (int i = 0; i < R; i++) a_data[i*N +: N] = a_beats[k][i];
    for (int j = 0; j < C; j++) b_data[j*N +: N] = b_beats[k][j];
    while (!fired && tries < 100) begin
      b_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (!b_valid) check("a_held_when_b_low", W'(a_ready_s), W'(0));
      fired = a_valid && a_ready_s && b_valid && b_ready_s;
      @(posedge clk); #1;
      tries++;
    end
    if (!fired) begin
      n_vec++; n_err++;
      $display("FAIL beat_timeout: got no transfer expected beat %0d", k);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // One job; abort_after >= 0 resets the design after that many beats.
  task automatic run_job(input bit stall, input int hold, input int abort_after,
                         input logic [W-1:0] es, input logic [W-1:0] ew);
    int t, e;
    logic [W-1:0] snap;
    t = 0;
    while (busy_s && t < 100) begin @(posedge clk); #1; t++; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", W'(busy_s), W'(1));
    if (abort_after >= 0) begin
      for (int k = 0; k < abort_after; k++) do_beat(k, stall);
      a_valid = 1'b1; b_valid = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", W'(busy_s), W'(0));
      check("abort_a_ready", W'(a_ready_s), W'(0));
      check("abort_res_valid", W'(res_valid_s), W'(0));
      a_valid = 1'b0; b_valid = 1'b0;
      return;
    end
    q_s.push_back(es);
    q_w.push_back(ew);
    for (int k = 0; k < K; k++) do_beat(k, stall);
    e = 0;
    do begin @(posedge clk); #1; e++; end while (!res_valid_s && e < 50);
    check("result_latency", W'(e), W'(R + C));
    snap = res_data_s;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_data_stable", res_data_s, snap);
      check("hold_busy", W'({busy_s, res_valid_s, done_s}), W'(3'b110));
    end
    res_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    start = 1'b0;
    check("done_pulse", W'({done_s, res_valid_s, busy_s}), W'(3'b100));
    @(posedge clk); #1;
    check("done_one_cycle", W'({done_s, busy_s}), W'(2'b00));
  endtask

  logic [W-1:0] e4s, e4w;

  initial begin
    rst = 1'b1; start = 1'b0; a_valid = 1'b0; b_valid = 1'b1; res_ready = 1'b0;
    a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", W'({busy_s, a_ready_s, b_ready_s, res_valid_s, done_s}), W'(0));
    check("reset_data", res_data_s, W'(0));
    rst = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;

    // 1: all ones times twos
    set_uniform(8'd1, 8'd2);
    run_job(1'b0, 0, -1, fill(8'd32), fill(8'd32));

    // 2/3: positive overflow clamps or wraps
    set_uniform(8'd127, 8'd127);
    run_job(1'b0, 0, -1, fill(8'h7f), fill(8'h10));

    // 2: negative overflow clamps to -128; 260096 is a multiple of 256
    set_uniform(8'h80, 8'd127);
    run_job(1'b0, 0, -1, fill(8'h80), fill(8'h00));

    // 4: lane-indexed operands with B stalls, expected 16*(i+1)*(j+1)
    set_lanes();
    e4s = '0; e4w = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        int v;
        v = 16 * (i + 1) * (j + 1);
        e4s[(i*C+j)*M +: M] = (v > 127) ? 8'd127 : M'(v);
        e4w[(i*C+j)*M +: M] = M'(v);
      end
    run_job(1'b1, 0, -1, e4s, e4w);

    // 5: result held while consumer is not ready
    set_uniform(8'd1, 8'd2);
    run_job(1'b0, 10, -1, fill(8'd32), fill(8'd32));

    // 6: reset mid-job, then a clean job
    run_job(1'b0, 0, 5, '0, '0);
    run_job(1'b0, 0, -1, fill(8'd32), fill(8'd32));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", W'(q_s.size() + q_w.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
